hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core.
- Generates the synchronous hold/clear pair for each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
- Resolves four hazard sources:
  - data-memory wait;
  - multi-cycle multiply/divide occupancy of EX;
  - load-use dependency;
  - taken-branch flush.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MD_LAT, 4, cycles the multiply/divide unit occupies EX beyond its first cycle; legal range 1..15.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  5  destination register of the load in EX.
- ex_md_start  input  1  instruction in EX is mult/div.
- ex_branch_taken  input  1  branch in EX resolved taken.
- mem_req  input  1  instruction in MEM accesses data memory.
- mem_ready  input  1  data memory completes this cycle.
- hold_pc  output  1  freeze PC.
- hold_ifid, clear_ifid  output  1 each  IF/ID register control.
- hold_idex, clear_idex  output  1 each  ID/EX register control.
- hold_exmem, clear_exmem  output  1 each  EX/MEM register control.
- hold_memwb, clear_memwb  output  1 each  MEM/WB register control.
- md_busy  output  1  FSM in MD_BUSY with count != 0.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN, md_cnt = 0, stall_cnt = 0.
  - While rst_n is low: all clear_* = 1, all hold_* = 0, hold_pc = 0, md_busy = 0. Pipeline registers therefore clear on the clock edges during reset.
- hold/clear outputs are combinational from state and inputs. Zero added latency: they take effect at the next posedge.
- Per-register invariant: clear and hold are never both 1 (the pipeline register gives clear priority, but the controller must never rely on that).
- Condition definitions:
  - mem_stall = mem_req & ~mem_ready.
  - md_stall = (state==RUN & ex_md_start) | (state==MD_BUSY & md_cnt!=0).
  - load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - flush = ex_branch_taken.
- Priority, highest first; exactly one case drives the outputs:
  1. mem_stall: hold_pc, hold_ifid, hold_idex, hold_exmem = 1; clear_memwb = 1 (bubble into WB).
  2. md_stall: hold_pc, hold_ifid, hold_idex = 1; clear_exmem = 1.
  3. flush: clear_ifid = 1, clear_idex = 1; PC advances to the branch target. Overrides load_use, because that consumer is wrong-path.
  4. load_use: hold_pc, hold_ifid = 1; clear_idex = 1. Lasts one cycle; forwarding covers the following cycle.
  5. None of the above: all outputs 0.
- A suppressed flush or load_use is not latched. ID/EX is held during higher-priority stalls, so the condition re-presents next cycle.
- FSM states:
  - RUN
    - ex_md_start & ~mem_stall → MD_BUSY, md_cnt = MD_LAT-1.
    - Otherwise stay in RUN.
  - MD_BUSY
    - mem_stall: md_cnt holds.
    - md_cnt != 0: md_cnt decrements.
    - md_cnt == 0: no MD stall this cycle (ID/EX advances); next state RUN.
    - ex_md_start is ignored in MD_BUSY. A back-to-back mult/div is accepted once it reaches EX in RUN.
- Total stall cycles for an isolated mult/div = MD_LAT.
- md_cnt width is 4 bits.
- stall_cnt increments on any cycle where hold_pc = 1. It saturates at all-ones and never wraps.
- Reset asserted mid-MD_BUSY: state returns to RUN immediately. The in-flight mult/div is discarded by the pipeline clears.

Decomposition:
- Package hazard_ctrl_pkg:
  - ctrl_state_t enum {RUN, MD_BUSY};
  - REG_W = 5;
  - REG_ZERO = 5'd0;
  - a packed struct pipe_ctl_t carrying one {hold, clear} pair per pipeline register.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output count). Used for stall_cnt.

Test Plan:
- Reset: rst_n low two cycles → all clear_* = 1, holds = 0, stall_cnt = 0. After release with idle inputs, all outputs 0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 → one cycle of hold_pc=hold_ifid=clear_idex=1. Same stimulus with ex_rt=0 → no stall.
- Mult with MD_LAT=4: ex_md_start=1 → exactly 4 cycles of hold_idex=clear_exmem=1, then release. md_busy is high for 3 of them. stall_cnt += 4.
- Mem wait during MD_BUSY: mem_ready=0 for 2 cycles with md_cnt=2 → mem_stall outputs win and md_cnt stays 2. Total MD stall = MD_LAT + 2 cycles.
- Flush vs load_use: ex_branch_taken=1 and load_use both true → only clear_ifid=clear_idex=1, hold_pc=0. Adding mem_stall the same cycle → mem_stall outputs only, no clears on IF/ID or ID/EX.
- Saturation: preload stall_cnt near max (CNT_W=4, force 14) and stall 3 cycles → 15, 15, 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    localparam int          REG_W    = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic hold_ifid;
        logic clear_ifid;
        logic hold_idex;
        logic clear_idex;
        logic hold_exmem;
        logic clear_exmem;
        logic hold_memwb;
        logic clear_memwb;
    } pipe_ctl_t;

    // Control word that clears every pipeline register and holds nothing
    function automatic pipe_ctl_t ctl_clear_all();
        pipe_ctl_t c;
        c = '0;
        c.clear_ifid  = 1'b1;
        c.clear_idex  = 1'b1;
        c.clear_exmem = 1'b1;
        c.clear_memwb = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating up-counter used for the stall-cycle statistic
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already all-ones, so the statistic sticks at max instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hold/clear generation for the 5-stage pipeline registers and PC
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_md_start,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             clear_ifid,
    output logic             hold_idex,
    output logic             clear_idex,
    output logic             hold_exmem,
    output logic             clear_exmem,
    output logic             hold_memwb,
    output logic             clear_memwb,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_t state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        md_busy_q, md_busy_d;

    logic        mem_stall;
    logic        md_stall;
    logic        load_use;
    logic        flush;
    pipe_ctl_t   ctl;
    logic        hold_pc_c;

    assign mem_stall = mem_req & ~mem_ready;
    assign md_stall  = ((state_q == RUN) & ex_md_start) |
                       ((state_q == MD_BUSY) & (md_cnt_q != 4'd0));
    assign load_use  = ex_memread & (ex_rt != REG_ZERO) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign flush     = ex_branch_taken;

    // Priority resolution: one hazard source owns the control word each cycle
    always_comb begin
        ctl       = '0;
        hold_pc_c = 1'b0;
        if (!rst_n) begin
            ctl = ctl_clear_all();
        end else if (mem_stall) begin
            hold_pc_c       = 1'b1;
            ctl.hold_ifid   = 1'b1;
            ctl.hold_idex   = 1'b1;
            ctl.hold_exmem  = 1'b1;
            ctl.clear_memwb = 1'b1;
        end else if (md_stall) begin
            hold_pc_c       = 1'b1;
            ctl.hold_ifid   = 1'b1;
            ctl.hold_idex   = 1'b1;
            ctl.clear_exmem = 1'b1;
        end else if (flush) begin
            // The load-use consumer in ID is wrong-path, so the flush wins
            ctl.clear_ifid  = 1'b1;
            ctl.clear_idex  = 1'b1;
        end else if (load_use) begin
            hold_pc_c       = 1'b1;
            ctl.hold_ifid   = 1'b1;
            ctl.clear_idex  = 1'b1;
        end
    end

    // Next-state for the mult/div occupancy tracker; a memory wait freezes it in place
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (!mem_stall) begin
            case (state_q)
                RUN: begin
                    if (ex_md_start) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = 4'(MD_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q != 4'd0) begin
                        md_cnt_d = md_cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        md_busy_d = (state_d == MD_BUSY) && (md_cnt_d != 4'd0);
    end

    // FSM state, counter and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            md_cnt_q  <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold_pc_c),
        .count (stall_cnt)
    );

    assign hold_pc     = hold_pc_c;
    assign hold_ifid   = ctl.hold_ifid;
    assign clear_ifid  = ctl.clear_ifid;
    assign hold_idex   = ctl.hold_idex;
    assign clear_idex  = ctl.clear_idex;
    assign hold_exmem  = ctl.hold_exmem;
    assign clear_exmem = ctl.clear_exmem;
    assign hold_memwb  = ctl.hold_memwb;
    assign clear_memwb = ctl.clear_memwb;
    assign md_busy     = md_busy_q;

endmodule
